mem_responder: RTL and testbench

- Word-wide memory responder: the target end of the CPU memory/fetch interface, which returns instruction and load words and commits stores.
- Accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Returns exactly one response pulse per accepted request.
- Sits between the CPU's address register / write-data path and the data provider that feeds fetched instructions into the decoder.

---
 rtl/mem_responder.sv | 214 +++++++++++++++++++++
 tb/tb_mem_responder.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Target end of the CPU memory/fetch interface. Accepts one word request at a
// time over a valid/ready handshake, waits WAIT_STATES cycles, then returns a
// single-cycle response carrying the read word (or the freshly written word
// for a store) and an error flag for misaligned / out-of-range addresses.
//
// Parameters:
//   ADDR_WIDTH   word-address bits; memory holds 2**ADDR_WIDTH words
//   WAIT_STATES  extra cycles between accept and response (0..15)
//   INIT_WORD    power-on content of every word
//
// Ports:
//   clk         clock, all logic on the rising edge
//   reset       synchronous, active-high
//   req_valid   request present
//   req_write   1 = store, 0 = load/fetch
//   req_addr    byte address; word index = req_addr[ADDR_WIDTH+1:2]
//   req_wdata   store data
//   req_be      byte-lane enables (only with MEM_RESPONDER_BYTE_WRITE_EN)
//   req_ready   responder can accept (registered)
//   resp_valid  one-cycle response strobe
//   resp_rdata  read data, meaningful while resp_valid=1
//   resp_error  request rejected, meaningful while resp_valid=1
//
// Build option:
//   MEM_RESPONDER_BYTE_WRITE_EN  adds req_be; stores update enabled lanes only.
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] INIT_WORD   = 32'hE1A00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    input  logic [3:0]  req_be,
`endif
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // Configuration sanity: reported at elaboration so a bad build never runs.
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
        $error("mem_responder: WAIT_STATES=%0d outside legal range 0..15", WAIT_STATES);
    end
    if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr_width
        $error("mem_responder: ADDR_WIDTH=%0d outside supported range 1..29", ADDR_WIDTH);
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_count;
    logic                    r_req_ready;
    logic                    r_resp_valid;
    logic                    r_resp_error;

    // Request captured at accept
    logic                    r_write;
    logic                    r_err;
    logic [ADDR_WIDTH-1:0]   r_idx;
    logic [31:0]             r_wdata;

    logic                    w_accept;
    logic                    w_in_err;
    logic [ADDR_WIDTH-1:0]   w_in_idx;
    logic [3:0]              w_in_be;
    logic                    w_to_resp;
    logic                    w_use_live;
    logic                    w_write;
    logic                    w_err;
    logic [ADDR_WIDTH-1:0]   w_idx;
    logic [31:0]             w_wdata;
    logic [3:0]              w_be;
    logic                    w_commit;

`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    logic [3:0]              r_be;
    assign w_in_be = req_be;
`else
    assign w_in_be = 4'hF;
`endif

    assign w_accept = (r_state == ST_IDLE) && r_req_ready && req_valid;
    assign w_in_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign w_in_idx = req_addr[ADDR_WIDTH+1:2];

    // The edge that enters RESP is the commit/read edge. With zero wait states
    // that edge is the accept edge itself, so the live request is used there;
    // otherwise the captured copy is used.
    assign w_to_resp  = !reset && (((r_state == ST_WAIT) && (r_count == 4'd0)) ||
                                   (w_accept && (WAIT_STATES == 0)));
    assign w_use_live = (r_state == ST_IDLE);
    assign w_write    = w_use_live ? req_write : r_write;
    assign w_err      = w_use_live ? w_in_err  : r_err;
    assign w_idx      = w_use_live ? w_in_idx  : r_idx;
    assign w_wdata    = w_use_live ? req_wdata : r_wdata;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
    assign w_be       = w_use_live ? w_in_be   : r_be;
`else
    assign w_be       = w_in_be;
`endif
    assign w_commit   = w_to_resp && w_write && !w_err;

    // Control FSM with registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= 4'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= 32'd0;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
            r_be         <= 4'd0;
`endif
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_err       <= w_in_err;
                        r_idx       <= w_in_idx;
                        r_wdata     <= req_wdata;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
                        r_be        <= w_in_be;
`endif
                        r_req_ready <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            r_state <= ST_WAIT;
                            r_count <= WAIT_LOAD;
                        end else begin
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_error <= w_in_err;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_count == 4'd0) begin
                        r_state      <= ST_RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= r_err;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // Storage split into byte lanes so partial stores need no read-modify-write.
    // Each lane returns the newly written byte on a store (write-first), the
    // stored byte otherwise, and zero for a rejected request.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] r_mem [DEPTH] = '{default: INIT_WORD[8*gi +: 8]};
        logic [7:0] r_rdata_lane;

        always_ff @(posedge clk) begin
            if (w_commit && w_be[gi]) begin
                r_mem[w_idx] <= w_wdata[8*gi +: 8];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                r_rdata_lane <= 8'd0;
            end else if (w_to_resp) begin
                if (w_err) begin
                    r_rdata_lane <= 8'd0;
                end else if (w_write && w_be[gi]) begin
                    r_rdata_lane <= w_wdata[8*gi +: 8];
                end else begin
                    r_rdata_lane <= r_mem[w_idx];
                end
            end
        end

        assign resp_rdata[8*gi +: 8] = r_rdata_lane;
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_error = r_resp_error;

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Two responders share clock and reset: index 0 uses WAIT_STATES=2, index 1
// uses WAIT_STATES=0. A word-array model computes expected responses from the
// address/alignment rules; a vector table, hand-written reset and throughput
// sequences, and random traffic are all checked against it.
// -----------------------------------------------------------------------------
module tb_mem_responder;

    localparam logic [31:0] INIT = 32'hE1A00000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic [1:0]       t_valid;
    logic [1:0]       t_write;
    logic [1:0][31:0] t_addr;
    logic [1:0][31:0] t_wdata;
    logic [1:0][3:0]  t_be;
    logic [1:0]       o_ready;
    logic [1:0]       o_rvalid;
    logic [1:0]       o_err;
    logic [1:0][31:0] o_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [2][1024];

    mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2), .INIT_WORD(INIT)) u_dut0 (
        .clk        (clk),
        .reset      (rst),
        .req_valid  (t_valid[0]),
        .req_write  (t_write[0]),
        .req_addr   (t_addr[0]),
        .req_wdata  (t_wdata[0]),
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
        .req_be     (t_be[0]),
`endif
        .req_ready  (o_ready[0]),
        .resp_valid (o_rvalid[0]),
        .resp_rdata (o_rdata[0]),
        .resp_error (o_err[0])
    );

    mem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(0), .INIT_WORD(INIT)) u_dut1 (
        .clk        (clk),
        .reset      (rst),
        .req_valid  (t_valid[1]),
        .req_write  (t_write[1]),
        .req_addr   (t_addr[1]),
        .req_wdata  (t_wdata[1]),
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
        .req_be     (t_be[1]),
`endif
        .req_ready  (o_ready[1]),
        .resp_valid (o_rvalid[1]),
        .resp_rdata (o_rdata[1]),
        .resp_error (o_err[1])
    );

    function automatic int ws(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a word is addressable only if aligned and below 4 KiB.
    task automatic model_op(input int d, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be,
                            output logic [31:0] rd, output logic er);
        logic [31:0] w;
        logic [3:0]  eff_be;
        int          idx;
`ifdef MEM_RESPONDER_BYTE_WRITE_EN
        eff_be = be;
`else
        eff_be = 4'hF | be;
`endif
        er = ((addr % 4) != 0) || (addr >= 32'h1000);
        rd = 32'd0;
        if (!er) begin
            idx = int'(addr / 4);
            if (wr) begin
                w = mdl[d][idx];
                for (int b = 0; b < 4; b++)
                    if (eff_be[b]) w[8*b +: 8] = wd[8*b +: 8];
                mdl[d][idx] = w;
            end
            rd = mdl[d][idx];
        end
    endtask

    // One request: present at a negedge, then hold junk with valid high while
    // busy (must be ignored), look for the response within a bounded window.
    task automatic txn(input int d, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] exp_d, input logic exp_e, input string name);
        int          lat;
        logic [31:0] got_d;
        logic        got_e;
        logic        rdy_low_ok;
        chk({name, "/ready_pre"}, 32'(o_ready[d]), 32'd1);
        t_valid[d] = 1'b1; t_write[d] = wr; t_addr[d] = addr; t_wdata[d] = wd; t_be[d] = be;
        @(negedge clk);
        lat = 0; got_d = 'x; got_e = 1'bx; rdy_low_ok = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            if (o_ready[d]) rdy_low_ok = 1'b0;
            if (o_rvalid[d]) begin
                lat = k; got_d = o_rdata[d]; got_e = o_err[d];
                t_valid[d] = 1'b0;
                break;
            end
            t_valid[d] = 1'b1; t_write[d] = 1'b1;
            t_addr[d] = $urandom & 32'h0000_0FFC; t_wdata[d] = $urandom; t_be[d] = 4'($urandom);
            @(negedge clk);
        end
        t_valid[d] = 1'b0;
        chk({name, "/latency"}, 32'(lat), 32'(ws(d) + 1));
        chk({name, "/rdata"}, got_d, exp_d);
        chk({name, "/error"}, 32'(got_e), 32'(exp_e));
        chk({name, "/ready_busy"}, 32'(rdy_low_ok), 32'd1);
        @(negedge clk);
        chk({name, "/ready_post"}, 32'(o_ready[d]), 32'd1);
        chk({name, "/pulse_once"}, 32'(o_rvalid[d]), 32'd0);
        $display("txn dut=%0d %s wr=%0d addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                 d, name, wr, addr, wd, got_d, got_e, lat);
    endtask

    task automatic mtxn(input int d, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input string name);
        logic [31:0] ed;
        logic        ee;
        model_op(d, wr, addr, wd, be, ed, ee);
        txn(d, wr, addr, wd, be, ed, ee, name);
    endtask

    task automatic rand_txn(input int d);
        logic [31:0] a;
        int          r;
        r = $urandom_range(0, 9);
        if (r < 7)       a = 32'($urandom_range(0, 15)) << 2;
        else if (r == 7) a = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(1, 3));
        else if (r == 8) a = 32'h1000 | ($urandom & 32'hFFFF_FFFC);
        else             a = 32'hFF0 + (32'($urandom_range(0, 3)) << 2);
        mtxn(d, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), "rand");
    endtask

    // Store, then reset on a chosen cycle after accept; no response may follow.
    task automatic reset_during(input int rst_cycle, input logic [31:0] addr,
                                input logic [31:0] wd, input string name);
        logic seen;
        t_valid[0] = 1'b1; t_write[0] = 1'b1; t_addr[0] = addr; t_wdata[0] = wd; t_be[0] = 4'hF;
        @(negedge clk);
        t_valid[0] = 1'b0;
        seen = 1'b0;
        for (int k = 1; k < rst_cycle; k++) begin
            if (o_rvalid[0]) seen = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (o_rvalid[0]) seen = 1'b1;
            @(negedge clk);
        end
        chk({name, "/no_resp"}, 32'(seen), 32'd0);
        chk({name, "/ready"}, 32'(o_ready[0]), 32'd1);
        chk({name, "/rdata_cleared"}, o_rdata[0], 32'd0);
        $display("txn dut=0 %s store addr=%h wdata=%h aborted by reset", name, addr, wd);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vt[11];

    initial begin
        logic [31:0] dd;
        logic        de;
        int          issued;
        int          iss_cyc[3];
        int          rsp_cyc[$];
        logic [31:0] rsp_dat[$];

        vt[0]  = '{1'b0, 32'h0000_0010, 32'h0,         INIT,          1'b0};
        vt[1]  = '{1'b1, 32'h0000_0020, 32'hDEADBEEF,  32'hDEADBEEF,  1'b0};
        vt[2]  = '{1'b0, 32'h0000_0020, 32'h0,         32'hDEADBEEF,  1'b0};
        vt[3]  = '{1'b0, 32'h0000_0022, 32'h0,         32'h0,         1'b1};
        vt[4]  = '{1'b0, 32'h0000_1000, 32'h0,         32'h0,         1'b1};
        vt[5]  = '{1'b0, 32'h0000_0000, 32'h0,         INIT,          1'b0};
        vt[6]  = '{1'b1, 32'h0000_0021, 32'hCAFEF00D,  32'h0,         1'b1};
        vt[7]  = '{1'b0, 32'h0000_0020, 32'h0,         32'hDEADBEEF,  1'b0};
        vt[8]  = '{1'b1, 32'h0000_0FFC, 32'h0000_0001, 32'h0000_0001, 1'b0};
        vt[9]  = '{1'b0, 32'h0000_0FFC, 32'h0,         32'h0000_0001, 1'b0};
        vt[10] = '{1'b1, 32'h8000_0020, 32'h55555555,  32'h0,         1'b1};

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 1024; i++) mdl[d][i] = INIT;

        rst = 1'b1;
        t_valid = '0; t_write = '0; t_addr = '0; t_wdata = '0; t_be = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset%0d/ready", d), 32'(o_ready[d]), 32'd1);
            chk($sformatf("reset%0d/valid", d), 32'(o_rvalid[d]), 32'd0);
            chk($sformatf("reset%0d/rdata", d), o_rdata[d], 32'd0);
            chk($sformatf("reset%0d/error", d), 32'(o_err[d]), 32'd0);
        end

        // Table vectors with hand-computed expectations; model kept in step.
        for (int i = 0; i < 11; i++) begin
            model_op(0, vt[i].wr, vt[i].addr, vt[i].wd, 4'hF, dd, de);
            txn(0, vt[i].wr, vt[i].addr, vt[i].wd, 4'hF, vt[i].exp_d, vt[i].exp_e,
                $sformatf("vec%0d", i));
        end

        // Reset while waiting, and reset on the edge that would enter RESP.
        reset_during(1, 32'h0000_0004, 32'h12345678, "rst_wait");
        txn(0, 1'b0, 32'h0000_0004, 32'h0, 4'hF, INIT, 1'b0, "after_rst_wait");
        reset_during(2, 32'h0000_0008, 32'hA5A5A5A5, "rst_resp_edge");
        txn(0, 1'b0, 32'h0000_0008, 32'h0, 4'hF, INIT, 1'b0, "after_rst_resp_edge");
        mtxn(0, 1'b0, 32'h0000_0020, 32'h0, 4'hF, "mem_survives_reset");

`ifdef MEM_RESPONDER_BYTE_WRITE_EN
        mtxn(0, 1'b1, 32'h0000_0030, 32'h11223344, 4'hF, "be_full");
        txn(0, 1'b1, 32'h0000_0030, 32'hFFFFFFFF, 4'b0101, 32'h11FF33FF, 1'b0, "be_0101");
        model_op(0, 1'b1, 32'h0000_0030, 32'hFFFFFFFF, 4'b0101, dd, de);
        txn(0, 1'b0, 32'h0000_0030, 32'h0, 4'h0, 32'h11FF33FF, 1'b0, "be_readback");
        txn(0, 1'b1, 32'h0000_0030, 32'h0, 4'h0, 32'h11FF33FF, 1'b0, "be_none");
        model_op(0, 1'b1, 32'h0000_0030, 32'h0, 4'h0, dd, de);
        txn(0, 1'b0, 32'h0000_0030, 32'h0, 4'hF, 32'h11FF33FF, 1'b0, "be_none_readback");
`endif

        // Zero wait states: seed three words, then three loads with valid held high.
        mtxn(1, 1'b1, 32'h0000_0100, 32'hAAAA0001, 4'hF, "b2b_seed0");
        mtxn(1, 1'b1, 32'h0000_0104, 32'hBBBB0002, 4'hF, "b2b_seed1");
        mtxn(1, 1'b1, 32'h0000_0108, 32'hCCCC0003, 4'hF, "b2b_seed2");
        issued = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (o_rvalid[1]) begin
                rsp_cyc.push_back(cyc);
                rsp_dat.push_back(o_rdata[1]);
            end
            if (issued < 3) begin
                t_valid[1] = 1'b1;
                if (o_ready[1]) begin
                    t_write[1] = 1'b0;
                    t_addr[1]  = 32'h0000_0100 + 32'(4 * issued);
                    iss_cyc[issued] = cyc;
                    issued++;
                end else begin
                    t_write[1] = 1'b1;
                    t_addr[1]  = $urandom & 32'h0000_0FFC;
                    t_wdata[1] = $urandom;
                end
            end else begin
                t_valid[1] = 1'b0;
            end
            @(negedge clk);
        end
        chk("b2b/issued", 32'(issued), 32'd3);
        chk("b2b/resp_count", 32'(rsp_cyc.size()), 32'd3);
        for (int i = 0; i < 3 && i < rsp_cyc.size(); i++) begin
            chk($sformatf("b2b%0d/accept_cycle", i), 32'(iss_cyc[i]), 32'(2 * i));
            chk($sformatf("b2b%0d/resp_cycle", i), 32'(rsp_cyc[i]), 32'(iss_cyc[i] + 1));
            chk($sformatf("b2b%0d/rdata", i), rsp_dat[i], mdl[1][64 + i]);
            $display("txn dut=1 b2b%0d load addr=%h rdata=%h cyc=%0d",
                     i, 32'h100 + 32'(4 * i), rsp_dat[i], rsp_cyc[i]);
        end

        for (int i = 0; i < 40; i++) rand_txn(0);
        for (int i = 0; i < 30; i++) rand_txn(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
